// File: rtl/scope_pkg.sv
// Shared types and constants for the scope trigger/capture block.
package scope_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    CAPT,
    DONE
  } cap_state_t;

  typedef enum logic {
    SLOPE_RISE,
    SLOPE_FALL
  } slope_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// A read that hits the address being written returns the previous contents.
module scope_capture_ram #(
  parameter int N     = 12,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // Write and registered read; non-blocking update gives read-old on collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_trigger_capture.sv
// Circular-buffer oscilloscope capture: arm, pre-trigger fill, level/slope
// trigger, post-trigger fill, then trigger-relative readout.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [N-1:0]  sample,
  input  logic          arm,
  input  logic [N-1:0]  trig_level,
  input  logic          trig_slope,
  input  logic [AW-1:0] pretrig,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic [AW-1:0] start_index
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  cap_state_t    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] remain_reg, remain_next;
  logic [AW-1:0] pretrig_reg, pretrig_next;
  logic [AW-1:0] start_index_reg, start_index_next;
  logic [N-1:0]  level_reg, level_next;
  logic [N-1:0]  prev_reg, prev_next;
  slope_t        slope_reg, slope_next;
  logic          prev_ok_reg, prev_ok_next;
  logic          triggered_reg, triggered_next;
  logic          rd_live_reg;

  logic          acq_active;
  logic          wr_en;
  logic          rise_hit;
  logic          fall_hit;
  logic          trig_hit;
  logic [N-1:0]  ram_rdata;

  // Samples are only stored while acquiring, and an arm in the same cycle wins.
  assign acq_active = (state_reg == PRE) || (state_reg == WAIT) || (state_reg == CAPT);
  assign wr_en      = sample_valid && !arm && acq_active;

  // Edge detection against the previous valid sample, unsigned compares.
  assign rise_hit = (prev_reg < level_reg) && (sample >= level_reg);
  assign fall_hit = (prev_reg > level_reg) && (sample <= level_reg);
  assign trig_hit = prev_ok_reg && ((slope_reg == SLOPE_FALL) ? fall_hit : rise_hit);

  // Next-state logic for the acquisition FSM, pointers and counters.
  always_comb begin
    state_next       = state_reg;
    wr_ptr_next      = wr_ptr_reg;
    cnt_next         = cnt_reg;
    remain_next      = remain_reg;
    pretrig_next     = pretrig_reg;
    start_index_next = start_index_reg;
    level_next       = level_reg;
    prev_next        = prev_reg;
    slope_next       = slope_reg;
    prev_ok_next     = prev_ok_reg;
    triggered_next   = triggered_reg;

    if (arm) begin
      level_next     = trig_level;
      slope_next     = slope_t'(trig_slope);
      // A full-frame pre-trigger leaves exactly one slot: the trigger sample.
      pretrig_next   = (pretrig >= LAST_IDX) ? LAST_IDX : pretrig;
      cnt_next       = '0;
      remain_next    = '0;
      prev_ok_next   = 1'b0;
      triggered_next = 1'b0;
      state_next     = (pretrig == '0) ? WAIT : PRE;
    end else if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
      unique case (state_reg)
        PRE: begin
          prev_next    = sample;
          prev_ok_next = 1'b1;
          cnt_next     = cnt_reg + 1'b1;
          if (cnt_next == pretrig_reg) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          prev_next    = sample;
          prev_ok_next = 1'b1;
          if (trig_hit) begin
            start_index_next = wr_ptr_reg - pretrig_reg;
            triggered_next   = 1'b1;
            remain_next      = LAST_IDX - pretrig_reg;
            state_next       = (remain_next == '0) ? DONE : CAPT;
          end
        end
        CAPT: begin
          remain_next = remain_reg - 1'b1;
          if (remain_next == '0) begin
            state_next = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      cnt_reg         <= '0;
      remain_reg      <= '0;
      pretrig_reg     <= '0;
      start_index_reg <= '0;
      level_reg       <= '0;
      prev_reg        <= '0;
      slope_reg       <= SLOPE_RISE;
      prev_ok_reg     <= 1'b0;
      triggered_reg   <= 1'b0;
      rd_live_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      cnt_reg         <= cnt_next;
      remain_reg      <= remain_next;
      pretrig_reg     <= pretrig_next;
      start_index_reg <= start_index_next;
      level_reg       <= level_next;
      prev_reg        <= prev_next;
      slope_reg       <= slope_next;
      prev_ok_reg     <= prev_ok_next;
      triggered_reg   <= triggered_next;
      rd_live_reg     <= 1'b1;
    end
  end

  scope_capture_ram #(
    .N    (N),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_reg),
    .wdata(sample),
    .raddr(start_index_reg + rd_addr),
    .rdata(ram_rdata)
  );

  // The RAM output register has no reset, so mask it for the cycle after reset.
  assign rd_data     = rd_live_reg ? ram_rdata : '0;
  assign busy        = acq_active;
  assign triggered   = triggered_reg;
  assign done        = (state_reg == DONE);
  assign start_index = start_index_reg;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with a 16-sample frame.
module tb_scope_trigger_capture;

  localparam int N     = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [N-1:0]  sample;
  logic          arm;
  logic [N-1:0]  trig_level;
  logic          trig_slope;
  logic [AW-1:0] pretrig;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] start_index;

  int n_cmp = 0;
  int n_bad = 0;

  scope_trigger_capture #(
    .N    (N),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .arm         (arm),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .pretrig     (pretrig),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .triggered   (triggered),
    .done        (done),
    .start_index (start_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s);
    sample_valid = 1'b1;
    sample       = N'(s);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input int lvl, input logic slp, input int pre);
    arm        = 1'b1;
    trig_level = N'(lvl);
    trig_slope = slp;
    pretrig    = AW'(pre);
    tick();
    arm = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a, input int exp);
    rd_addr = AW'(a);
    tick();
    check_eq(tag, int'(rd_data), exp);
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample = '0; arm = 1'b0;
    trig_level = '0; trig_slope = 1'b0; pretrig = '0; rd_addr = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_trig", int'(triggered), 0);
    check_eq("rst_start", int'(start_index), 0);
    check_eq("rst_rd_data", int'(rd_data), 0);

    // Rising edge, pretrig 4, ramp 0,10,20,...; wr_ptr starts at 0.
    do_arm(100, 1'b0, 4);
    check_eq("rise_busy_armed", int'(busy), 1);
    for (int i = 0; i < 10; i++) push(i * 10);
    check_eq("rise_no_trig_yet", int'(triggered), 0);
    push(100);
    check_eq("rise_trig", int'(triggered), 1);
    check_eq("rise_start", int'(start_index), 6);
    for (int i = 11; i < 21; i++) push(i * 10);
    check_eq("rise_not_done_10", int'(done), 0);
    push(210);
    check_eq("rise_done", int'(done), 1);
    check_eq("rise_busy_off", int'(busy), 0);
    for (int i = 0; i < DEPTH; i++) read_chk($sformatf("rise_rd%0d", i), i, 60 + 10 * i);

    // Falling edge, pretrig 0; wr_ptr = 6.
    do_arm(2048, 1'b1, 0);
    check_eq("fall_done_cleared", int'(done), 0);
    check_eq("fall_trig_cleared", int'(triggered), 0);
    push(4095);
    push(3000);
    check_eq("fall_no_trig_3000", int'(triggered), 0);
    push(2048);
    check_eq("fall_trig", int'(triggered), 1);
    check_eq("fall_start", int'(start_index), 8);
    push(1000);
    check_eq("fall_trig_held", int'(triggered), 1);
    check_eq("fall_busy", int'(busy), 1);
    for (int i = 0; i < 14; i++) push(500 + i);
    check_eq("fall_done", int'(done), 1);
    read_chk("fall_rd0", 0, 2048);
    read_chk("fall_rd1", 1, 1000);

    // First-sample filtering with pretrig 0; wr_ptr = 8.
    do_arm(100, 1'b0, 0);
    push(500);
    check_eq("filt_first_500", int'(triggered), 0);
    push(50);
    check_eq("filt_50", int'(triggered), 0);
    push(150);
    check_eq("filt_trig_150", int'(triggered), 1);
    check_eq("filt_start", int'(start_index), 10);
    for (int i = 0; i < 15; i++) push(300 + i);
    check_eq("filt_done", int'(done), 1);
    read_chk("filt_rd0", 0, 150);
    read_chk("filt_rd15", 15, 314);

    // Re-arm in WAIT colliding with a sample; wr_ptr = 10.
    do_arm(100, 1'b0, 0);
    push(10);
    push(20);
    arm = 1'b1; trig_level = N'(100); trig_slope = 1'b0; pretrig = '0;
    sample_valid = 1'b1; sample = N'(50);
    tick();
    arm = 1'b0; sample_valid = 1'b0;
    push(150);
    check_eq("coll_first_no_trig", int'(triggered), 0);
    push(50);
    push(150);
    check_eq("coll_trig", int'(triggered), 1);
    check_eq("coll_start", int'(start_index), 14);
    for (int i = 0; i < 15; i++) push(700 + i);
    check_eq("coll_done", int'(done), 1);
    read_chk("coll_rd0", 0, 150);
    read_chk("coll_rd15", 15, 714);

    // Largest representable pretrig (15): done on the trigger sample; wr_ptr = 14.
    do_arm(100, 1'b0, 15);
    for (int i = 0; i < 15; i++) push(i * 5);
    check_eq("clamp_wait_no_trig", int'(triggered), 0);
    check_eq("clamp_busy", int'(busy), 1);
    push(100);
    check_eq("clamp_trig", int'(triggered), 1);
    check_eq("clamp_done", int'(done), 1);
    check_eq("clamp_start", int'(start_index), 14);
    push(999);
    read_chk("clamp_rd0", 0, 0);
    read_chk("clamp_rd1", 1, 5);
    read_chk("clamp_rd14", 14, 70);
    read_chk("clamp_rd15", 15, 100);

    // Reset in the middle of CAPT.
    do_arm(100, 1'b0, 0);
    push(50);
    push(150);
    push(200);
    check_eq("mid_capt_busy", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mrst_busy", int'(busy), 0);
    check_eq("mrst_done", int'(done), 0);
    check_eq("mrst_trig", int'(triggered), 0);
    check_eq("mrst_start", int'(start_index), 0);
    check_eq("mrst_rd_data", int'(rd_data), 0);
    push(50);
    push(150);
    check_eq("idle_ignore_busy", int'(busy), 0);
    check_eq("idle_ignore_trig", int'(triggered), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
